// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: per-stage instruction
// records, forwarding selects and the register-dependency test.
package pipe_ctrl_pkg;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // Source fields are only meaningful in EX; MEM/WB simply carry them along.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       setflags;
    logic       is_mul;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '0;

  function automatic logic reg_dep(input stage_rec_t rec,
                                   input logic [4:0] src,
                                   input logic       use_src,
                                   input logic [4:0] xzr = XZR_IDX);
    return rec.valid & rec.regwrite & use_src & (rec.rd == src) & (rec.rd != xzr);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX-stage operand forwarding: pick the youngest producer (MEM over WB)
// of each EX source register.
module pipe_fwd_unit import pipe_ctrl_pkg::*; #(
  parameter logic [4:0] XZR = XZR_IDX
) (
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic       ex_use_rs1,
  input  logic       ex_use_rs2,
  input  stage_rec_t mem_rec,
  input  stage_rec_t wb_rec,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

  function automatic fwd_sel_t pick(input stage_rec_t m, input stage_rec_t w,
                                    input logic [4:0] src, input logic use_src);
    if (reg_dep(m, src, use_src, XZR))      return FWD_EXMEM;
    else if (reg_dep(w, src, use_src, XZR)) return FWD_MEMWB;
    else                                    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = pick(mem_rec, wb_rec, ex_rs1, ex_use_rs1);
    fwd_b = pick(mem_rec, wb_rec, ex_rs2, ex_use_rs2);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline: shadow scoreboard of
// EX/MEM/WB, stall/flush/redirect generation and forwarding selects.
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
  parameter int         MUL_LAT = 4,
  parameter logic [4:0] XZR     = XZR_IDX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_setflags,
  input  logic       id_readflags,
  input  logic       id_is_mul,
  input  logic       ex_branch_taken,
  output logic       pc_en,
  output logic       pc_sel_br,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mul_busy
);

  localparam logic [2:0] MUL_LOAD = 3'(MUL_LAT - 1);

  stage_rec_t ex_rec, mem_rec, wb_rec, id_rec;
  logic [2:0] mul_cnt, mul_cnt_nxt;
  logic       branch, mul_hold, load_use, flag_use;
  fwd_sel_t   fwd_a_sel, fwd_b_sel;

  // An invalid ID slot is a bubble, so it can never raise a hazard.
  always_comb begin
    id_rec = REC_BUBBLE;
    if (id_valid) begin
      id_rec.valid    = 1'b1;
      id_rec.rd       = id_rd;
      id_rec.regwrite = id_regwrite;
      id_rec.memread  = id_memread;
      id_rec.setflags = id_setflags;
      id_rec.is_mul   = id_is_mul;
      id_rec.rs1      = id_rs1;
      id_rec.rs2      = id_rs2;
      id_rec.use_rs1  = id_use_rs1;
      id_rec.use_rs2  = id_use_rs2;
    end
  end

  always_comb begin
    branch   = ex_branch_taken & ex_rec.valid;
    mul_hold = (mul_cnt != 3'd0);
    load_use = ex_rec.memread &
               (reg_dep(ex_rec, id_rec.rs1, id_rec.use_rs1, XZR) |
                reg_dep(ex_rec, id_rec.rs2, id_rec.use_rs2, XZR));
    flag_use = id_valid & id_readflags & ex_rec.valid & ex_rec.setflags;
  end

  always_comb begin
    pc_en       = 1'b1;
    pc_sel_br   = 1'b0;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mul_busy    = 1'b0;
    mul_cnt_nxt = mul_cnt;
    if (branch) begin
      pc_sel_br   = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      mul_cnt_nxt = 3'd0;
    end else if (mul_hold) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
      mul_busy    = 1'b1;
      mul_cnt_nxt = mul_cnt - 3'd1;
    end else if (load_use | flag_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
    // A MUL stalled in ID never reaches this load, so the hold cannot retrigger.
    if (idex_en && !idex_flush && id_rec.valid && id_rec.is_mul)
      mul_cnt_nxt = MUL_LOAD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_rec  <= REC_BUBBLE;
      mem_rec <= REC_BUBBLE;
      wb_rec  <= REC_BUBBLE;
      mul_cnt <= 3'd0;
    end else begin
      wb_rec  <= mem_rec;
      mem_rec <= exmem_flush ? REC_BUBBLE : ex_rec;
      if (idex_flush)   ex_rec <= REC_BUBBLE;
      else if (idex_en) ex_rec <= id_rec;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  pipe_fwd_unit #(.XZR(XZR)) u_fwd (
    .ex_rs1     (ex_rec.rs1),
    .ex_rs2     (ex_rec.rs2),
    .ex_use_rs1 (ex_rec.use_rs1),
    .ex_use_rs2 (ex_rec.use_rs2),
    .mem_rec    (mem_rec),
    .wb_rec     (wb_rec),
    .fwd_a      (fwd_a_sel),
    .fwd_b      (fwd_b_sel)
  );

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage pipelined ARM CPU (IF, RF/ID, EX, MEM, WB). It keeps a shadow scoreboard of the instruction metadata in each stage. From that it generates the pipeline-register enables, bubbles and flushes, and the EX-stage operand forwarding selects. Covered hazards: load-use, flag-use (B.LT after a flag-setting instruction), multi-cycle MUL occupancy of EX, and taken-branch redirect.

Parameters:
MUL_LAT, 4, EX-stage cycles a MUL occupies; legal range 1..8.
XZR, 5'd31, register index never treated as a dependency.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low (0 = reset asserted)
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  5  Rn read index
id_rs2  in  5  second read index (post Reg2Loc mux)
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  5  destination index
id_regwrite  in  1  instruction writes rd
id_memread  in  1  instruction is LDUR
id_setflags  in  1  instruction sets NZVC
id_readflags  in  1  instruction consumes flags (B.LT)
id_is_mul  in  1  instruction is MUL
ex_branch_taken  in  1  branch in EX resolved taken
pc_en  out  1  PC register load enable
pc_sel_br  out  1  PC loads branch target instead of PC+4
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID register loads NOP
idex_en  out  1  ID/EX register enable
idex_flush  out  1  ID/EX register loads bubble
exmem_flush  out  1  EX/MEM register loads bubble
fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  same for operand B
mul_busy  out  1  multiply in progress in EX

Behaviour:
- Scoreboard: records for EX, MEM and WB, each holding valid, rd, regwrite, memread, setflags, is_mul. The EX record also holds rs1/rs2/use bits. All records advance on clk.
- Reset (async, low): every record valid=0, mul counter=0. During reset: enables=1, flushes=0, pc_sel_br=0, fwd=00, mul_busy=0. A reset mid-MUL abandons the multiply.
- Dependency match: valid & regwrite & rd==src & use_src & rd!=XZR.
- Priority, highest first:
  1. Branch: ex_branch_taken & EX.valid. pc_sel_br=1, pc_en=1, ifid_flush=1, idex_flush=1. Branch beats any stall. The penalty is 2 bubbles.
  2. MUL hold: mul counter !=0. pc_en=ifid_en=idex_en=0, exmem_flush=1, mul_busy=1. The counter decrements each cycle.
  3. Load-use: EX.memread matches an ID source. pc_en=ifid_en=0, idex_flush=1 (exactly 1 bubble).
  4. Flag-use: id_readflags & EX.valid & EX.setflags. Same 1-bubble stall as load-use.
  5. Otherwise, all enables are 1 and all flushes are 0.
- MUL counter: when a MUL enters EX (idex_en & !idex_flush & id_is_mul), the counter loads MUL_LAT-1. With MUL_LAT=1 there is no hold. The MUL advances to MEM in the cycle the counter reaches 0. An ID instruction stalled behind a MUL does not re-trigger the counter.
- Record update:
  - EX record: on idex_flush it becomes a bubble; else if idex_en it captures the ID inputs; else it holds.
  - MEM record: on exmem_flush it becomes a bubble; else it takes EX.
  - WB record always takes MEM.
  - id_valid=0 is treated as a bubble.
- Forwarding (combinational from the EX record): a MEM match gives 01. Otherwise a WB match gives 10. Otherwise 00. MEM is youngest, so MEM wins when both match.
  - MEM.memread matching an EX source is unreachable. The bench asserts this never happens.
- Simultaneous cases:
  - Branch plus MUL start in the same cycle: the MUL is flushed and the counter is not loaded.
  - Load-use plus flag-use together still cost one bubble total.

Decomposition:
- pipe_ctrl_pkg holds:
  - typedef fwd_sel_t (FWD_RF, FWD_EXMEM, FWD_MEMWB)
  - struct stage_rec_t
  - constant XZR_IDX
  - function reg_dep(rec, src, use)
- One sub-module, pipe_fwd_unit: the combinational forwarding compare on the EX/MEM/WB records.

Test Plan:
- ADDS X1,X2,X3 then SUBS X4,X1,X1 back-to-back -> fwd_a=fwd_b=01 in the SUBS EX cycle, no stall. An intervening NOP gives fwd=10.
- LDUR X5,[X0,#0] then ADD X6,X5,X7 -> exactly 1 cycle with pc_en=0 and idex_flush=1, then fwd_a=10.
- SUBS X9,X1,X2 then B.LT -> one 1-cycle stall. With a NOP between them, no stall.
- MUL X3,X1,X2 with MUL_LAT=4 -> mul_busy high 3 cycles, pc_en=0 for 3 cycles, 3 MEM bubbles. A following dependent ADD then gets fwd=01.
- B taken in EX with ex_branch_taken=1 -> pc_sel_br=1, ifid_flush=idex_flush=1 for 1 cycle. A load-use hazard in the same cycle is ignored.
- Assert reset low on the 2nd cycle of a MUL hold -> mul_busy=0 and fwd=00 immediately. After release, a fresh ADD flows with no stall.
